matrix_tx_scheduler: RTL and testbench
======================================

Name: matrix_tx_scheduler

Overview:
- Shares one ethernet transmit path (bitorder_out -> ether_out) among NUM_SRC matrix_compiler instances.
- Grants the link round-robin to sources holding a complete frame, then fires the preamble trigger.
- Forwards ether_out's data_request to the granted source only, muxes that source's byte stream onto the link, and counts bytes to frame end.
- Enforces an inter-frame gap before the next grant.

Parameters:
NUM_SRC, 2, number of matrix sources (2..8)
FRAME_BYTES, 1024, bytes per frame (32x32 8-bit matrix)
IFG_CYCLES, 48, idle clk cycles between frames (>=1)
TIMEOUT_CYCLES, 4096, stall limit, used only with optional feature

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
src_ready  in  NUM_SRC  level per source: complete frame compiled (compile_done)
src_byte  in  8*NUM_SRC  byte from source i at [8i+7:8i]
src_valid  in  NUM_SRC  byte qualifier per source
src_request  out  NUM_SRC  forwarded data_request, one-hot to granted source
src_ack  out  NUM_SRC  1-cycle pulse to source whose frame finished
tx_start  out  1  1-cycle pulse to ether_out preamble_signal
tx_request  in  1  data_request from ether_out
tx_byte  out  8  byte to bitorder_out axiid
tx_valid  out  1  qualifier to bitorder_out axiiv
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_SRC)  index of current/last granted source
frame_count  out  16  frames completed; wraps 0xFFFF->0
err_abort  out  1  sticky; set only by optional feature

Behaviour:
- Reset: one clock, asynchronous active-low reset; rst_n low forces state IDLE immediately.
  - All outputs go to 0: src_request, src_ack, tx_start, tx_byte, tx_valid, busy, grant_id, frame_count, err_abort.
  - Byte counter 0; last_grant = NUM_SRC-1, so source 0 wins first.
  - Reset mid-frame abandons the frame; no src_ack is issued.
- States:
  - IDLE: if any src_ready, pick the first ready index circularly starting at last_grant+1. Latch grant_id and last_grant, go START.
  - START: tx_start=1 for exactly this cycle; go WAIT_REQ.
  - WAIT_REQ: wait for tx_request=1, then go STREAM.
  - STREAM: src_request[grant_id] = tx_request (combinational); all other bits 0.
    - Each cycle, tx_byte/tx_valid are registered copies of src_byte/src_valid of grant_id (latency 1 cycle).
    - Counter increments on each granted src_valid.
    - When src_valid arrives with counter==FRAME_BYTES-1, that byte is forwarded and the state goes to ACK.
  - ACK: src_ack[grant_id]=1 for one cycle; frame_count++; counter cleared; go GAP.
  - GAP: count IFG_CYCLES cycles with src_request=0, then go IDLE.
- Non-granted src_valid is ignored in all states.
- Granted src_valid outside STREAM is dropped: tx_valid stays 0.
- tx_valid and tx_byte are 0 in every state other than the cycle after a forwarded byte.
- src_ready dropping mid-frame has no effect; the frame completes on byte count only.
- A single ready source is re-granted after GAP if still ready; no starvation with round-robin.
- tx_request falling during STREAM removes src_request the same cycle. Byte count is held, not reset.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - In WAIT_REQ or STREAM, a stall counter counts cycles without a granted src_valid (WAIT_REQ counts all cycles).
  - Reaching TIMEOUT_CYCLES sets err_abort (sticky until reset) and goes to GAP.
  - Abort path: no src_ack, frame_count unchanged, counter cleared.
- Undefined: no stall counter; the scheduler waits indefinitely; err_abort tied 0.

Test Plan:
1. Only src_ready[0]=1, source answers each request with 1024 bytes 0xAA/0xFF alternating -> one tx_start pulse; 1024 tx_valid bytes identical in order at 1-cycle latency; src_ack[0] pulse; frame_count=1; then 48 idle cycles before the next tx_start.
2. src_ready=2'b11 held -> grant order 0,1,0,1; each frame exactly 1024 bytes; src_request never has two bits set.
3. During source 0's frame, source 1 drives src_valid=1 byte 0x55 every cycle -> 0x55 never appears on tx_byte; source 0 count still 1024.
4. tx_request deasserted for 20 cycles mid-frame at byte 500 -> src_request[grant] low for those cycles; frame resumes and ends at 1024 bytes total.
5. rst_n pulsed low at byte 300 -> all outputs 0 asynchronously; no src_ack; next frame after release is granted to source 0 and counts from 0.
6. SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=64, source stops sending after byte 10 -> err_abort=1 after 64 stall cycles; frame_count unchanged; GAP then IDLE.

Source files
------------

// File: rtl/matrix_tx_scheduler.sv
// Round-robin scheduler sharing one ethernet transmit path among NUM_SRC frame sources.
// Optional stall watchdog with sticky abort flag: define SCHED_TIMEOUT_EN.
module matrix_tx_scheduler #(
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned FRAME_BYTES    = 1024,
    parameter int unsigned IFG_CYCLES     = 48,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         src_ready_i,
    input  logic [8*NUM_SRC-1:0]       src_byte_i,
    input  logic [NUM_SRC-1:0]         src_valid_i,
    output logic [NUM_SRC-1:0]         src_request_o,
    output logic [NUM_SRC-1:0]         src_ack_o,
    output logic                       tx_start_o,
    input  logic                       tx_request_i,
    output logic [7:0]                 tx_byte_o,
    output logic                       tx_valid_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_SRC)-1:0] grant_id_o,
    output logic [15:0]                frame_count_o,
    output logic                       err_abort_o
);

    localparam int unsigned GW = $clog2(NUM_SRC);
    localparam int unsigned CW = $clog2(FRAME_BYTES + 1);
    localparam int unsigned IW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_REQ, S_STREAM, S_ACK, S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d, last_q, last_d, pick;
    logic               found;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      gap_q, gap_d;
    logic [15:0]        fcnt_q, fcnt_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [7:0]         byte_q, byte_d;
    logic               g_valid;
    logic [7:0]         g_byte;
    logic [NUM_SRC-1:0] req_c;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] stall_q, stall_d;
    logic          err_q, err_d;
`endif

    assign g_valid = src_valid_i[grant_q];
    assign g_byte  = src_byte_i[{grant_q, 3'b000} +: 8];

    // First ready source searching circularly from the one after last_q.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            if (!found && src_ready_i[GW'((32'(last_q) + i) % NUM_SRC)]) begin
                found = 1'b1;
                pick  = GW'((32'(last_q) + i) % NUM_SRC);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        fcnt_d  = fcnt_q;
        valid_d = 1'b0;
        byte_d  = 8'h00;
`ifdef SCHED_TIMEOUT_EN
        stall_d = '0;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    last_d  = pick;
                    state_d = S_START;
                end
            end
            S_START:    state_d = S_WAIT_REQ;
            S_WAIT_REQ: if (tx_request_i) state_d = S_STREAM;
            S_STREAM: begin
                if (g_valid) begin
                    valid_d = 1'b1;
                    byte_d  = g_byte;
                    if (cnt_q == CW'(FRAME_BYTES - 1)) begin
                        cnt_d   = '0;
                        fcnt_d  = fcnt_q + 16'd1;
                        state_d = S_ACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ACK: begin
                cnt_d   = '0;
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == IW'(IFG_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef SCHED_TIMEOUT_EN
        // WAIT_REQ stalls every cycle; STREAM only on cycles without a granted byte.
        if (state_q == S_WAIT_REQ || (state_q == S_STREAM && !g_valid)) begin
            if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                cnt_d   = '0;
                gap_d   = '0;
                state_d = S_GAP;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
`endif
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
        ack_d   = '0;
        if (state_d == S_ACK) ack_d[grant_d] = 1'b1;
    end

    // Request is forwarded straight through to the granted source only.
    always_comb begin
        req_c = '0;
        if (state_q == S_STREAM) req_c[grant_q] = tx_request_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_SRC - 1);
            cnt_q   <= '0;
            gap_q   <= '0;
            fcnt_q  <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            byte_q  <= 8'h00;
`ifdef SCHED_TIMEOUT_EN
            stall_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            fcnt_q  <= fcnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
`ifdef SCHED_TIMEOUT_EN
            stall_q <= stall_d;
            err_q   <= err_d;
`endif
        end
    end

    assign src_request_o = req_c;
    assign src_ack_o     = ack_q;
    assign tx_start_o    = start_q;
    assign tx_byte_o     = byte_q;
    assign tx_valid_o    = valid_q;
    assign busy_o        = busy_q;
    assign grant_id_o    = grant_q;
    assign frame_count_o = fcnt_q;

`ifdef SCHED_TIMEOUT_EN
    assign err_abort_o = err_q;
`else
    // The timeout length only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign err_abort_o    = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_tx_scheduler.sv
// Scoreboard bench for matrix_tx_scheduler: random source/link behaviour against a
// frame-level round-robin model; a monitor pops expected bytes and grants.
module tb_matrix_tx_scheduler;

    localparam int N   = 2;
    localparam int FB  = 1024;
    localparam int IFG = 48;
    localparam int TO  = 64;

    logic                 clk, rst_n;
    logic [N-1:0]         src_ready_i, src_valid_i, src_request_o, src_ack_o;
    logic [8*N-1:0]       src_byte_i;
    logic                 tx_start_o, tx_request_i, tx_valid_o, busy_o, err_abort_o;
    logic [7:0]           tx_byte_o;
    logic [$clog2(N)-1:0] grant_id_o;
    logic [15:0]          frame_count_o;

    matrix_tx_scheduler #(
        .NUM_SRC(N), .FRAME_BYTES(FB), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_ready_i(src_ready_i), .src_byte_i(src_byte_i), .src_valid_i(src_valid_i),
        .src_request_o(src_request_o), .src_ack_o(src_ack_o), .tx_start_o(tx_start_o),
        .tx_request_i(tx_request_i), .tx_byte_o(tx_byte_o), .tx_valid_o(tx_valid_o),
        .busy_o(busy_o), .grant_id_o(grant_id_o), .frame_count_o(frame_count_o),
        .err_abort_o(err_abort_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    logic [7:0]  frame_mem [N][FB];
    int          ptr [N];
    logic [7:0]  exp_q [$];
    logic [15:0] exp_fc;
    int          last_g, cur_g, rx_cnt, acks, cyc, ack_cyc;
    bit          active, have_ack, ready_gap_ok, junk_start;
    // Stimulus controls
    int          stall_at, hold_cnt, stop_at;
    logic [7:0]  b;
    int          g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic int rr_pick(input int lst, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[(lst + i) % N]) return (lst + i) % N;
        end
        return lst;
    endfunction

    task automatic gen_frame(input int s);
        for (int k = 0; k < FB; k++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            if (v == 8'h55) v = 8'h56;
            frame_mem[s][k] = v;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        active   = 0;
        have_ack = 0;
        last_g   = N - 1;
        exp_fc   = '0;
        rx_cnt   = 0;
        for (int s = 0; s < N; s++) ptr[s] = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_src_request"}, 32'(src_request_o), 0);
        check({tag, "_src_ack"},     32'(src_ack_o), 0);
        check({tag, "_tx_start"},    32'(tx_start_o), 0);
        check({tag, "_tx_byte"},     32'(tx_byte_o), 0);
        check({tag, "_tx_valid"},    32'(tx_valid_o), 0);
        check({tag, "_busy"},        32'(busy_o), 0);
        check({tag, "_grant_id"},    32'(grant_id_o), 0);
        check({tag, "_frame_count"}, 32'(frame_count_o), 0);
        check({tag, "_err_abort"},   32'(err_abort_o), 0);
    endtask

    task automatic wait_acks(input int n, input string name);
        int target, budget;
        target = acks + n;
        budget = n * 4000;
        while (acks < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, 32'(acks >= target), 1);
    endtask

    // Link and source models: the granted source answers requests, others spray 0x55.
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_request_i = 1'b0;
            src_valid_i  = '0;
            src_byte_i   = '0;
        end else begin
            if (hold_cnt > 0) begin
                tx_request_i = 1'b0;
                hold_cnt--;
            end else if (stall_at >= 0 && active && ptr[cur_g] == stall_at) begin
                tx_request_i = 1'b0;
                hold_cnt     = 19;
                stall_at     = -1;
            end else begin
                tx_request_i = ($urandom_range(0, 9) != 0);
            end
            #1;
            for (int s = 0; s < N; s++) begin
                if (active && s == cur_g) begin
                    if (src_request_o[s] && ptr[s] < FB && !(stop_at >= 0 && ptr[s] >= stop_at)
                        && $urandom_range(0, 7) != 0) begin
                        src_valid_i[s]         = 1'b1;
                        src_byte_i[8*s +: 8]   = frame_mem[s][ptr[s]];
                        ptr[s]++;
                    end else if (junk_start) begin
                        src_valid_i[s]         = 1'b1;
                        src_byte_i[8*s +: 8]   = 8'h55;
                    end else begin
                        src_valid_i[s]         = 1'b0;
                        src_byte_i[8*s +: 8]   = 8'h00;
                    end
                end else begin
                    src_valid_i[s]       = 1'b1;
                    src_byte_i[8*s +: 8] = 8'h55;
                end
            end
            junk_start = 0;
        end
    end

    // Monitor: compares DUT outputs against the frame-level model.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst_n) begin
            if (src_ready_i == '0) ready_gap_ok = 0;
            check("req_onehot0", 32'($onehot0(src_request_o)), 1);
            if (!tx_request_i) check("req_gated", 32'(src_request_o), 0);
            if (src_request_o != '0) check("req_target", 32'(src_request_o), active ? 32'(onehot(cur_g)) : 0);
            if (tx_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("byte_unexpected", 32'(tx_byte_o), 32'h100);
                end else begin
                    b = exp_q.pop_front();
                    check("tx_byte", 32'(tx_byte_o), 32'(b));
                    rx_cnt++;
                end
            end else begin
                check("tx_byte_idle", 32'(tx_byte_o), 0);
            end
            if (tx_start_o) begin
                check("start_while_active", 32'(active), 0);
                g = rr_pick(last_g, src_ready_i);
                check("grant_id", 32'(grant_id_o), 32'(g));
                if (have_ack) begin
                    if (ready_gap_ok) check("ifg_exact", 32'(cyc - ack_cyc), 32'(IFG + 2));
                    else              check("ifg_min", 32'(cyc - ack_cyc >= IFG + 2), 1);
                end
                cur_g      = g;
                last_g     = g;
                active     = 1;
                rx_cnt     = 0;
                junk_start = 1;
                for (int k = 0; k < FB; k++) exp_q.push_back(frame_mem[g][k]);
            end
            if (src_ack_o != '0) begin
                check("ack_expected", 32'(active), 1);
                check("ack_onehot", 32'(src_ack_o), 32'(onehot(cur_g)));
                check("frame_len", 32'(rx_cnt), 32'(FB));
                exp_fc = exp_fc + 16'd1;
                check("frame_count", 32'(frame_count_o), 32'(exp_fc));
                active       = 0;
                gen_frame(cur_g);
                ptr[cur_g]   = 0;
                have_ack     = 1;
                ack_cyc      = cyc;
                ready_gap_ok = 1;
                acks++;
            end
            if (active) check("busy", 32'(busy_o), 1);
`ifndef SCHED_TIMEOUT_EN
            check("err_tied", 32'(err_abort_o), 0);
`endif
        end
    end

    initial begin
        bit hit;
        rst_n = 1'b0;
        src_ready_i = '0; src_valid_i = '0; src_byte_i = '0; tx_request_i = 1'b0;
        cyc = 0; acks = 0; stall_at = -1; hold_cnt = 0; stop_at = -1;
        junk_start = 0; ready_gap_ok = 0; ack_cyc = 0; cur_g = 0;
        model_reset();
        for (int s = 0; s < N; s++) gen_frame(s);
        for (int k = 0; k < FB; k++) frame_mem[0][k] = k[0] ? 8'hFF : 8'hAA;
        repeat (3) @(posedge clk);
        #1 reset_checks("reset");
        @(negedge clk) rst_n = 1'b1;

        // Single ready source: pattern frame, then re-grant after the gap.
        src_ready_i = 2'b01;
        wait_acks(2, "single_src_frames");
        src_ready_i = '0;

        // Both ready: alternating grants with junk from the idle source.
        src_ready_i = 2'b11;
        wait_acks(4, "rr_frames");

        // Link pauses for 20 cycles at byte 500.
        stall_at = 500;
        wait_acks(1, "stall_frame");
        check("stall_applied", 32'(stall_at), 32'hFFFF_FFFF);

        // Asynchronous reset at byte 300.
        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clk);
            #2;
            if (active && ptr[cur_g] >= 300) hit = 1;
        end
        check("reached_byte_300", 32'(hit), 1);
        rst_n = 1'b0;
        #1 reset_checks("midframe_reset");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (active) hit = 1;
        end
        check("regrant_after_reset", 32'(hit), 1);
        check("grant_after_reset", 32'(grant_id_o), 0);
        wait_acks(1, "frame_after_reset");
        @(negedge clk);
        check("fc_after_reset", 32'(frame_count_o), 1);
        src_ready_i = '0;

`ifdef SCHED_TIMEOUT_EN
        // Source stops after 10 bytes; watchdog must abort without an ack.
        repeat (IFG + 4) @(negedge clk);
        stop_at = 10;
        src_ready_i = 2'b01;
        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clk);
            if (err_abort_o) hit = 1;
        end
        check("err_abort_set", 32'(hit), 1);
        src_ready_i = '0;
        check("abort_frame_count", 32'(frame_count_o), 32'(exp_fc));
        check("bytes_before_abort", 32'(rx_cnt), 10);
        active = 0;
        exp_q.delete();
        ptr[cur_g] = 0;
        stop_at = -1;
        repeat (IFG + 4) @(negedge clk);
        check("idle_after_abort", 32'(busy_o), 0);
        check("err_sticky", 32'(err_abort_o), 1);
`endif

        repeat (IFG + 4) @(negedge clk);
        check("idle_at_end", 32'(busy_o), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
